// File: rtl/float_addsub_pipe.sv
// Pipelined IEEE-754 binary16/32/64 add/subtract: input register, align, add, normalise/round (RNE).
// Define FLOAT_ADD_SPECIAL_EN to decode Inf/NaN operands; otherwise an all-ones exponent is a finite value.
module float_addsub_pipe #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_c,
    output logic                  out_ovf
);
    localparam int W  = (DATA_WIDTH == 16) ? 16 : (DATA_WIDTH == 64) ? 64 : 32;
    localparam int E  = (W == 16) ? 5 : (W == 64) ? 11 : 8;
    localparam int M  = W - E - 1;
    localparam int SW = M + 4;
    localparam int LW = E + 3;
    localparam logic [E-1:0] EMAX = '1;
    localparam logic [E-1:0] DLIM = E'(M + 3);

    function automatic logic [LW-1:0] lzc(input logic [SW-1:0] v);
        logic [LW-1:0] n;
        n = LW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (v[i]) n = LW'(SW - 1 - i);
        end
        return n;
    endfunction

    // Returns {carry, hidden, mantissa} after round-to-nearest-even on {hidden, mant, G, R, S}.
    function automatic logic [M+1:0] rne(input logic [SW-1:0] n);
        logic up;
        up = n[2] & (n[1] | n[0] | n[3]);
        return {1'b0, n[SW-1:3]} + {{(M+1){1'b0}}, up};
    endfunction

    logic adv;
    logic vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q;
    logic [W-1:0] a_p0_q, b_p0_q;
    logic sub_p0_q;

    logic          a_s, b_s, a_big;
    logic [E-1:0]  a_e, b_e, y_e, d;
    logic [M-1:0]  a_m, b_m;
    logic [SW-1:0] y_sig;
    logic          sx_p1_d, esub_p1_d, zz_p1_d, zs_p1_d, sp_p1_d;
    logic [E-1:0]  ex_p1_d;
    logic [SW-1:0] mx_p1_d, my_p1_d;
    logic [W-1:0]  spv_p1_d;
    logic          sx_p1_q, esub_p1_q, zz_p1_q, zs_p1_q, sp_p1_q;
    logic [E-1:0]  ex_p1_q;
    logic [SW-1:0] mx_p1_q, my_p1_q;
    logic [W-1:0]  spv_p1_q;

    logic [SW:0]   sum_p2;
    logic [E:0]    e_p2_d, e_p2_q;
    logic [SW-1:0] m_p2_d, m_p2_q;
    logic          s_p2_q, zz_p2_q, zs_p2_q, sp_p2_q;
    logic [W-1:0]  spv_p2_q;

    logic [LW-1:0]        lz;
    logic [SW-1:0]        norm;
    logic [M+1:0]         rnd;
    logic signed [LW-1:0] e_n, e_r;
    logic [W-1:0]         c_d, c_q;
    logic                 ovf_d, ovf_q;

`ifdef FLOAT_ADD_SPECIAL_EN
    logic a_nan, b_nan, a_inf, b_inf;
`endif

    assign adv       = !vld_p3_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p3_q;
    assign out_c     = DATA_WIDTH'(c_q);
    assign out_ovf   = ovf_q;

    // S1: unpack, flush subnormals, swap larger magnitude into X, align Y with sticky
    always_comb begin
        a_s   = a_p0_q[W-1];
        a_e   = a_p0_q[W-2:M];
        a_m   = (a_e == '0) ? '0 : a_p0_q[M-1:0];
        b_s   = b_p0_q[W-1] ^ sub_p0_q;
        b_e   = b_p0_q[W-2:M];
        b_m   = (b_e == '0) ? '0 : b_p0_q[M-1:0];
        a_big = {a_e, a_m} >= {b_e, b_m};
        sx_p1_d = a_big ? a_s : b_s;
        ex_p1_d = a_big ? a_e : b_e;
        y_e     = a_big ? b_e : a_e;
        mx_p1_d = {(ex_p1_d != '0), (a_big ? a_m : b_m), 3'b000};
        y_sig   = {(y_e != '0), (a_big ? b_m : a_m), 3'b000};
        d       = ex_p1_d - y_e;
        if (d >= DLIM) begin
            my_p1_d = {{(SW-1){1'b0}}, |y_sig};
        end else begin
            my_p1_d    = y_sig >> d;
            my_p1_d[0] = my_p1_d[0] | (|(y_sig & ~({SW{1'b1}} << d)));
        end
        esub_p1_d = a_s ^ b_s;
        zz_p1_d   = (a_e == '0) && (b_e == '0);
        zs_p1_d   = a_s & b_s;
        sp_p1_d   = 1'b0;
        spv_p1_d  = '0;
`ifdef FLOAT_ADD_SPECIAL_EN
        a_nan = (a_e == EMAX) && (a_p0_q[M-1:0] != '0);
        b_nan = (b_e == EMAX) && (b_p0_q[M-1:0] != '0);
        a_inf = (a_e == EMAX) && (a_p0_q[M-1:0] == '0);
        b_inf = (b_e == EMAX) && (b_p0_q[M-1:0] == '0);
        if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
            sp_p1_d  = 1'b1;
            spv_p1_d = {1'b0, EMAX, 1'b1, {(M-1){1'b0}}};
        end else if (a_inf || b_inf) begin
            sp_p1_d  = 1'b1;
            spv_p1_d = {(a_inf ? a_s : b_s), EMAX, {M{1'b0}}};
        end
`else
        sp_p1_d  = 1'b0;
        spv_p1_d = '0;
`endif
    end

    // S2: magnitude add or subtract; carry-out renormalises right keeping sticky
    always_comb begin
        sum_p2 = {1'b0, mx_p1_q} + {1'b0, my_p1_q};
        e_p2_d = {1'b0, ex_p1_q};
        if (esub_p1_q) begin
            m_p2_d = mx_p1_q - my_p1_q;
        end else if (sum_p2[SW]) begin
            m_p2_d = {sum_p2[SW:2], sum_p2[1] | sum_p2[0]};
            e_p2_d = e_p2_d + {{E{1'b0}}, 1'b1};
        end else begin
            m_p2_d = sum_p2[SW-1:0];
        end
    end

    // S3: normalise, round, then resolve zero / underflow / overflow / specials
    always_comb begin
        lz    = lzc(m_p2_q);
        norm  = m_p2_q << lz;
        rnd   = rne(norm);
        e_n   = $signed({2'b00, e_p2_q}) - $signed(lz);
        e_r   = e_n + $signed({{(LW-1){1'b0}}, rnd[M+1]});
        c_d   = '0;
        ovf_d = 1'b0;
        if (sp_p2_q) begin
            c_d = spv_p2_q;
        end else if (m_p2_q == '0) begin
            c_d = {zz_p2_q & zs_p2_q, {(W-1){1'b0}}};
        end else if (e_n[LW-1] || (e_n == '0)) begin
            c_d = {s_p2_q, {(W-1){1'b0}}};
        end else if (e_r >= $signed({3'b000, EMAX})) begin
            c_d   = {s_p2_q, EMAX, {M{1'b0}}};
            ovf_d = 1'b1;
        end else begin
            c_d = {s_p2_q, e_r[E-1:0], (rnd[M+1] ? rnd[M:1] : rnd[M-1:0])};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
        end else if (adv) begin
            vld_p0_q <= in_valid;
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
            if (vld_p2_q) begin
                c_q   <= c_d;
                ovf_q <= ovf_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            a_p0_q    <= W'(in_a);
            b_p0_q    <= W'(in_b);
            sub_p0_q  <= in_sub;
            sx_p1_q   <= sx_p1_d;
            ex_p1_q   <= ex_p1_d;
            mx_p1_q   <= mx_p1_d;
            my_p1_q   <= my_p1_d;
            esub_p1_q <= esub_p1_d;
            zz_p1_q   <= zz_p1_d;
            zs_p1_q   <= zs_p1_d;
            sp_p1_q   <= sp_p1_d;
            spv_p1_q  <= spv_p1_d;
            s_p2_q    <= sx_p1_q;
            e_p2_q    <= e_p2_d;
            m_p2_q    <= m_p2_d;
            zz_p2_q   <= zz_p1_q;
            zs_p2_q   <= zs_p1_q;
            sp_p2_q   <= sp_p1_q;
            spv_p2_q  <= spv_p1_q;
        end
    end
endmodule

// File: tb/tb_float_addsub_pipe.sv
// Bench for float_addsub_pipe: directed fp16/32/64 cases, reset behaviour, and a randomized
// fp32 stream scored against a real-arithmetic reference model.
module tb_float_addsub_pipe;
    logic clk, rst;
    logic        iv16, ir16, sub16, ov16, or16, ovf16;
    logic [15:0] a16, b16, c16;
    logic        iv32, ir32, sub32, ov32, or32, ovf32;
    logic [31:0] a32, b32, c32;
    logic        iv64, ir64, sub64, ov64, or64, ovf64;
    logic [63:0] a64, b64, c64;

    int total = 0;
    int bad   = 0;

    float_addsub_pipe #(.DATA_WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
        .in_sub(sub16), .out_valid(ov16), .out_ready(or16), .out_c(c16), .out_ovf(ovf16));
    float_addsub_pipe #(.DATA_WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_a(a32), .in_b(b32),
        .in_sub(sub32), .out_valid(ov32), .out_ready(or32), .out_c(c32), .out_ovf(ovf32));
    float_addsub_pipe #(.DATA_WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .in_a(a64), .in_b(b64),
        .in_sub(sub64), .out_valid(ov64), .out_ready(or64), .out_c(c64), .out_ovf(ovf64));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic real pow2(int k);
        real r;
        r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real f2r(logic [31:0] x, logic s);
        real v;
        if (x[30:23] == 8'h00) return 0.0;
        v = (1.0 + real'(int'(x[22:0])) / 8388608.0) * pow2(int'(x[30:23]) - 127);
        return s ? -v : v;
    endfunction

    // Exact sum in double, rounded once to binary32 RNE with flush-to-zero and overflow to Inf.
    function automatic logic [32:0] model(logic [31:0] a, logic [31:0] b, logic sub);
        logic bs, neg;
        real  sum, m, q, f;
        int   e, fi;
        bs = b[31] ^ sub;
        if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {1'b0, a[31] & bs, 31'd0};
        sum = f2r(a, a[31]) + f2r(b, bs);
        if (sum == 0.0) return 33'd0;
        neg = (sum < 0.0);
        m = neg ? -sum : sum;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        if (e + 127 <= 0) return {1'b0, neg, 31'd0};
        q  = m * 8388608.0;
        f  = $floor(q);
        fi = $rtoi(f);
        if ((q - f > 0.5) || ((q - f == 0.5) && fi[0])) fi++;
        if (fi == 16777216) begin fi = 8388608; e++; end
        if (e + 127 >= 255) return {1'b1, neg, 8'hFF, 23'd0};
        return {1'b0, neg, 8'(e + 127), 23'(fi)};
    endfunction

    function automatic logic out_v(int w);
        case (w)
            16:      return ov16;
            64:      return ov64;
            default: return ov32;
        endcase
    endfunction

    function automatic logic [64:0] out_r(int w);
        case (w)
            16:      return {ovf16, 48'd0, c16};
            64:      return {ovf64, c64};
            default: return {ovf32, 32'd0, c32};
        endcase
    endfunction

    task automatic drive(int w, logic v, logic [63:0] a, logic [63:0] b, logic s);
        case (w)
            16:      begin iv16 = v; a16 = a[15:0]; b16 = b[15:0]; sub16 = s; or16 = 1'b1; end
            64:      begin iv64 = v; a64 = a;       b64 = b;       sub64 = s; or64 = 1'b1; end
            default: begin iv32 = v; a32 = a[31:0]; b32 = b[31:0]; sub32 = s; or32 = 1'b1; end
        endcase
    endtask

    // One isolated operation: checks latency from acceptance edge, result and overflow flag.
    task automatic op(int w, logic [63:0] a, logic [63:0] b, logic s,
                      logic [63:0] ec, logic eo, string tag);
        int lat;
        logic [64:0] r;
        @(negedge clk);
        drive(w, 1'b1, a, b, s);
        @(posedge clk);
        #1 drive(w, 1'b0, a, b, s);
        lat = 0;
        while (!out_v(w) && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        r = out_r(w);
        chk({tag, "_lat"}, 64'(lat), 64'(3));
        chk({tag, "_c"}, r[63:0], ec);
        chk({tag, "_ovf"}, 64'(r[64]), 64'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_op(output logic [31:0] a, output logic [31:0] b, output logic s);
        int ea, eb, k;
        k  = int'($urandom_range(0, 9));
        ea = int'($urandom_range(100, 150));
        eb = ea + int'($urandom_range(0, 60)) - 30;
        a  = {1'($urandom), 8'(ea), 23'($urandom)};
        b  = {1'($urandom), 8'(eb), 23'($urandom)};
        if (k == 0) b[30:23] = 8'h00;
        if (k == 1) begin
            b[30:23] = a[30:23];
            b[22:0]  = a[22:0] ^ 23'($urandom_range(0, 255));
        end
        if (k == 2) begin
            a[30:23] = 8'hFE;
            b[30:23] = 8'hFE - 8'($urandom_range(0, 2));
        end
        s = 1'($urandom);
    endtask

    // Stream n ops with random in_valid; out_ready toggles 1010.. or is random.
    task automatic stream(int n, logic toggle, string tag);
        logic [32:0] q[$];
        logic [32:0] exp_v, held;
        logic [31:0] ra, rb;
        logic        rs, held_v;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; held_v = 1'b0; held = '0;
        while (got < n && cyc < 4000) begin
            @(negedge clk);
            or32 = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            iv32 = (sent < n) && ($urandom_range(0, 2) != 0);
            if (iv32) begin
                rand_op(ra, rb, rs);
                a32 = ra; b32 = rb; sub32 = rs;
            end
            #1;
            if (held_v) begin
                chk({tag, "_stall_vld"}, 64'(ov32), 64'(1));
                chk({tag, "_stall_out"}, 64'({ovf32, c32}), 64'(held));
            end
            if (ov32 && or32) begin
                exp_v = (q.size() != 0) ? q.pop_front() : 'x;
                chk({tag, "_res"}, 64'({ovf32, c32}), 64'(exp_v));
                got++;
            end
            held_v = ov32 && !or32;
            held   = {ovf32, c32};
            if (iv32 && ir32) begin
                q.push_back(model(a32, b32, sub32));
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        iv32 = 1'b0;
        or32 = 1'b1;
        chk({tag, "_count"}, 64'(got), 64'(n));
        chk({tag, "_leftover"}, 64'(q.size()), 64'(0));
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        iv16 = 0; a16 = '0; b16 = '0; sub16 = 0; or16 = 1;
        iv32 = 0; a32 = '0; b32 = '0; sub32 = 0; or32 = 1;
        iv64 = 0; a64 = '0; b64 = '0; sub64 = 0; or64 = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_vld32", 64'(ov32), 64'(0));
        chk("rst_c32", 64'(c32), 64'(0));
        chk("rst_ovf32", 64'(ovf32), 64'(0));
        chk("rst_rdy32", 64'(ir32), 64'(1));
        chk("rst_vld16", 64'(ov16), 64'(0));
        chk("rst_vld64", 64'(ov64), 64'(0));

        op(32, 64'h3F800000, 64'h40000000, 1'b0, 64'h40400000, 1'b0, "add_1_2");
        op(32, 64'h3F800000, 64'h40000000, 1'b1, 64'hBF800000, 1'b0, "sub_1_2");
        op(32, 64'h3F800000, 64'h3F800000, 1'b1, 64'h00000000, 1'b0, "cancel");
        op(32, 64'h80000000, 64'h80000000, 1'b0, 64'h80000000, 1'b0, "negzero");
        op(32, 64'h3F800000, 64'h33800000, 1'b0, 64'h3F800000, 1'b0, "rne_tie");
        op(32, 64'h3F800000, 64'h34400000, 1'b0, 64'h3F800002, 1'b0, "rne_up");
        op(32, 64'h3F800000, 64'h33000000, 1'b0, 64'h3F800000, 1'b0, "rne_down");
        op(32, 64'h3F800000, 64'h00400000, 1'b0, 64'h3F800000, 1'b0, "subnorm_in");
        op(32, 64'h7F7FFFFF, 64'h7F7FFFFF, 1'b0, 64'h7F800000, 1'b1, "ovf");
`ifdef FLOAT_ADD_SPECIAL_EN
        op(32, 64'h7F800000, 64'hFF800000, 1'b0, 64'h7FC00000, 1'b0, "inf_minus_inf");
        op(32, 64'h7FC00000, 64'h3F800000, 1'b0, 64'h7FC00000, 1'b0, "nan_prop");
`endif

        stream(8, 1'b1, "s8");
        stream(300, 1'b0, "rnd");

        repeat (3) begin
            @(negedge clk);
            iv32 = 1'b1; a32 = 32'h3F800000; b32 = 32'h40000000; sub32 = 1'b0; or32 = 1'b1;
        end
        @(negedge clk);
        iv32 = 1'b0;
        rst  = 1'b1;
        #1 chk("midrst_vld_now", 64'(ov32), 64'(0));
        @(posedge clk);
        #1 chk("midrst_vld_next", 64'(ov32), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 chk("midrst_quiet", 64'(ov32), 64'(0));
        end
        op(32, 64'h40000000, 64'h3F800000, 1'b1, 64'h3F800000, 1'b0, "after_rst");

        op(16, 64'h3C00, 64'h4000, 1'b0, 64'h4200, 1'b0, "h_add");
        op(16, 64'h3C00, 64'h4000, 1'b1, 64'hBC00, 1'b0, "h_sub");
        op(16, 64'h7BFF, 64'h7BFF, 1'b0, 64'h7C00, 1'b1, "h_ovf");
        op(64, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000, 1'b0, "d_add");
        op(64, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, 64'h0000000000000000, 1'b0, "d_cancel");
        op(64, 64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000000, 1'b0, "d_tie");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
